// File: rtl/jtkcpu_ea_if.sv
// Bundle of the sequencer handshake, operand inputs, pointer-read bus and
// register write-back port used by the jtkcpu_ea effective-address unit.
interface jtkcpu_ea_if #(
  parameter int AW   = 16,
  parameter int NIDX = 4,
  parameter int SELW = 2
);
  logic                 start;
  logic [7:0]           postbyte;
  logic [SELW-1:0]      idx_sel;
  logic [NIDX*AW-1:0]   idx_regs;
  logic [15:0]          data;
  logic [7:0]           a;
  logic [7:0]           b;
  logic [AW-1:0]        pc;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        ea;
  logic                 mem_rd;
  logic [AW-1:0]        mem_addr;
  logic [7:0]           mem_din;
  logic                 mem_ack;
  logic                 wr_en;
  logic [SELW-1:0]      wr_sel;
  logic [AW-1:0]        wr_val;

  // Sequencer/arbiter side
  modport master (
    output start, postbyte, idx_sel, idx_regs, data, a, b, pc, mem_din, mem_ack,
    input  busy, done, ea, mem_rd, mem_addr, wr_en, wr_sel, wr_val
  );

  // Effective-address unit side
  modport slave (
    input  start, postbyte, idx_sel, idx_regs, data, a, b, pc, mem_din, mem_ack,
    output busy, done, ea, mem_rd, mem_addr, wr_en, wr_sel, wr_val
  );
endinterface

// File: rtl/jtkcpu_ea.sv
// Multi-cycle effective-address unit for JTKCPU indexed modes, with optional
// 16-bit pointer indirection. Define JTKCPU_EA_PCREL_EN for PC-relative modes C/D.
module jtkcpu_ea #(
  parameter int AW   = 16,
  parameter int NIDX = 4,
  parameter int SELW = 2
) (
  input  logic        clk,
  input  logic        rst,
  jtkcpu_ea_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CALC, IND_HI, IND_LO, DONE} state_t;

  state_t          state_reg, state_next;

  logic            long_reg;      // postbyte bit 7: 5-bit offset form
  logic [4:0]      pb_reg;        // postbyte bits 4:0
  logic [SELW-1:0] sel_reg;
  logic [15:0]     data_reg;
  logic [7:0]      a_reg;
  logic [7:0]      b_reg;
  logic [AW-1:0]   base_reg;
`ifdef JTKCPU_EA_PCREL_EN
  logic [AW-1:0]   pc_reg;
`endif
  logic [AW-1:0]   ea_reg;
  logic [AW-1:0]   wr_val_reg;
  logic            mem_rd_reg;
  logic [AW-1:0]   mem_addr_reg;
  logic [7:0]      hi_reg;

  logic [AW-1:0]   reg_arr [NIDX];
  logic [AW-1:0]   sel_base;

  generate
    for (genvar gi = 0; gi < NIDX; gi++) begin : g_unpack
      assign reg_arr[gi] = bus.idx_regs[gi*AW +: AW];
    end
  endgenerate

  assign sel_base = (int'(bus.idx_sel) < NIDX) ? reg_arr[bus.idx_sel] : '0;

  // Mode decode from the latched postbyte; stable from CALC through DONE
  logic [AW-1:0]   calc_base;
  logic [AW-1:0]   calc_off;
  logic [AW-1:0]   calc_ea;
  logic [AW-1:0]   calc_wv;
  logic            ind;
  logic            wb;

  always_comb begin
    calc_base = base_reg;
    calc_off  = '0;
    calc_wv   = base_reg;
    ind       = 1'b0;
    wb        = 1'b0;
    if (long_reg) begin
      calc_off = AW'($signed(pb_reg));
    end else begin
      ind = pb_reg[4];
      case (pb_reg[3:0])
        4'h0: begin wb = 1'b1; calc_wv = base_reg + AW'(1); end
        4'h1: begin wb = 1'b1; calc_wv = base_reg + AW'(2); end
        4'h2: begin wb = 1'b1; calc_off = '0 - AW'(1); calc_wv = base_reg - AW'(1); end
        4'h3: begin wb = 1'b1; calc_off = '0 - AW'(2); calc_wv = base_reg - AW'(2); end
        4'h5: calc_off = AW'($signed(b_reg));
        4'h6: calc_off = AW'($signed(a_reg));
        4'h8: calc_off = AW'($signed(data_reg[7:0]));
        4'h9: calc_off = AW'($signed(data_reg));
        4'hB: calc_off = AW'($signed({a_reg, b_reg}));
`ifdef JTKCPU_EA_PCREL_EN
        4'hC: begin calc_base = pc_reg; calc_off = AW'($signed(data_reg[7:0])); end
        4'hD: begin calc_base = pc_reg; calc_off = AW'($signed(data_reg)); end
`endif
        default: calc_off = '0;
      endcase
    end
    calc_ea = calc_base + calc_off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    state_next = ind ? IND_HI : DONE;
      IND_HI:  if (mem_rd_reg && bus.mem_ack) state_next = IND_LO;
      IND_LO:  if (mem_rd_reg && bus.mem_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each pointer byte takes a setup cycle (mem_rd low) before the request is raised
  always_ff @(posedge clk) begin
    if (rst) begin
      long_reg     <= 1'b0;
      pb_reg       <= '0;
      sel_reg      <= '0;
      data_reg     <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      base_reg     <= '0;
`ifdef JTKCPU_EA_PCREL_EN
      pc_reg       <= '0;
`endif
      ea_reg       <= '0;
      wr_val_reg   <= '0;
      mem_rd_reg   <= 1'b0;
      mem_addr_reg <= '0;
      hi_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            long_reg <= bus.postbyte[7];
            pb_reg   <= bus.postbyte[4:0];
            sel_reg  <= bus.idx_sel;
            data_reg <= bus.data;
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            base_reg <= sel_base;
`ifdef JTKCPU_EA_PCREL_EN
            pc_reg   <= bus.pc;
`endif
          end
        end
        CALC: begin
          ea_reg <= calc_ea;
          if (wb) wr_val_reg <= calc_wv;
        end
        IND_HI: begin
          if (!mem_rd_reg) begin
            mem_rd_reg   <= 1'b1;
            mem_addr_reg <= ea_reg;
          end else if (bus.mem_ack) begin
            hi_reg     <= bus.mem_din;
            mem_rd_reg <= 1'b0;
          end
        end
        IND_LO: begin
          if (!mem_rd_reg) begin
            mem_rd_reg   <= 1'b1;
            mem_addr_reg <= ea_reg + AW'(1);
          end else if (bus.mem_ack) begin
            ea_reg     <= AW'({hi_reg, bus.mem_din});
            mem_rd_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_reg == CALC) || (state_reg == IND_HI) || (state_reg == IND_LO);
  assign bus.done     = (state_reg == DONE);
  assign bus.wr_en    = (state_reg == DONE) && wb;
  assign bus.wr_sel   = sel_reg;
  assign bus.wr_val   = wr_val_reg;
  assign bus.ea       = ea_reg;
  assign bus.mem_rd   = mem_rd_reg;
  assign bus.mem_addr = mem_addr_reg;

endmodule
